piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per bit period on sdo.
- Drives an sgate strobe so a downstream D latch or flip-flop chain captures each bit while sdo is stable.
- It is the driving end of the serial d/g link that the team's latch and flip-flop receive elements consume.

Parameters:
- WIDTH, 8, word length in bits; must be >= 2.
- DIV, 1, clock cycles per serial bit; must be >= 1.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  WIDTH  parallel word to send.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block can accept a word this cycle.
- sdo  output  1  serial data out.
- sgate  output  1  capture strobe for the downstream latch; high only while sdo is stable.
- busy  output  1  high from the cycle after accept until the done cycle, inclusive.
- done  output  1  one-cycle pulse after the last bit period.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. rst is sampled only on the clk rising edge.
- Reset values: din_ready=1, sdo=0, sgate=0, busy=0, done=0. State returns to IDLE and all counters clear.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State IDLE:
  - din_ready=1, busy=0, sdo=0, sgate=0.
  - Accept occurs when din_valid and din_ready are both 1 at a clk edge (cycle 0).
  - On accept: load din into the shift register, set bit_cnt=WIDTH-1 and div_cnt=DIV-1, move to SHIFT.
- State SHIFT:
  - din_ready=0, busy=1.
  - sdo = current head bit: shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0.
  - Each bit is held for exactly DIV cycles. div_cnt decrements every cycle.
  - sgate=1 only in the cycle where div_cnt==0, i.e. the last cycle of each bit period. With DIV=1, sgate=1 for every SHIFT cycle.
  - When div_cnt==0 and bit_cnt!=0: shift toward the head, bit_cnt-1, div_cnt reloads to DIV-1.
  - When div_cnt==0 and bit_cnt==0: move to DONE.
- State DONE:
  - Lasts exactly one cycle: done=1, busy=1, sdo=0, sgate=0, din_ready=0.
  - Then returns to IDLE.
- Latency:
  - First bit appears on sdo in cycle 1.
  - Bit k occupies cycles 1+k*DIV through (k+1)*DIV.
  - done pulses in cycle WIDTH*DIV+1; din_ready returns to 1 in cycle WIDTH*DIV+2.
  - Minimum accept-to-accept spacing is WIDTH*DIV+2 cycles.
- din_valid while din_ready=0 is ignored; no queuing. din may change freely after accept.
- Reset mid-word: rst wins over every other event. The word is aborted and reset values apply from the next cycle; no done pulse is produced.
- rst and din_valid in the same cycle: no accept.
- Counter widths:
  - bit_cnt is $clog2(WIDTH) bits.
  - div_cnt is max(1,$clog2(DIV)) bits.
  - DIV=1 must synthesize with div_cnt permanently 0.
- Shift fill: the vacated end of the shift register fills with 0.

Decomposition:
- Shared header serial_defs.vh holds:
  - 2-bit state encodings: IDLE=0, SHIFT=1, DONE=2; 3 is illegal and recovers to IDLE.
  - The MSB_FIRST/LSB_FIRST constants, shared with the matching receive-side blocks.
- One sub-module, bit_timer (parameter DIV):
  - Inputs clk, rst, start, en.
  - Output tick, high in the last cycle of each bit period.
  - Reused by future serial blocks.
- The shift register and FSM stay in piso_serializer.

Test Plan:
- Reset: hold rst=1 for 3 cycles with din_valid=1 and din=8'hA5 -> din_ready=1, sdo=0, sgate=0, busy=0, done=0; no word sent.
- Basic send (WIDTH=8, DIV=1, MSB_FIRST=1): accept 8'hA5 -> sdo reads 1,0,1,0,0,1,0,1 in cycles 1-8 with sgate=1 each cycle; done=1 in cycle 9; din_ready=1 in cycle 10.
- LSB-first with DIV=3 (MSB_FIRST=0): send 8'h01 -> sdo=1 in cycles 1-3 and 0 in cycles 4-24; sgate high only in cycles 3,6,...,24; done in cycle 25.
- Back-to-back: send 8'hFF then 8'h00 with din_valid held high -> second accept occurs exactly in cycle 10; the extra din_valid cycles while busy are ignored; the second word's sdo is all 0.
- Reset mid-word: pulse rst in cycle 4 of an 8'hA5 send -> reset values from cycle 5; no done pulse; the next word transmits correctly.
- Latch loopback: feed sdo and sgate into a d_latch chain sampling on sgate -> the captured bit sequence equals the sent word for DIV in {1,2,4}.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial d/g link: FSM state encoding and bit-order constants,
// also used by the matching receive-side blocks.
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ORDER_LSB_FIRST = 0;
    localparam int ORDER_MSB_FIRST = 1;

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// Bit-period timer: counts DIV cycles per serial bit and raises a registered tick
// in the last cycle of each period.
module bit_timer #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] nxt_cnt;

    always_comb begin
        nxt_cnt = (div_cnt == '0) ? RELOAD : div_cnt - 1'b1;
    end

    // tick is registered from the count value the next cycle will hold, so it lines up
    // with div_cnt==0 without a combinational decode on the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (start) begin
            div_cnt <= RELOAD;
            tick    <= (RELOAD == '0);
        end else if (en) begin
            div_cnt <= nxt_cnt;
            tick    <= (nxt_cnt == '0);
        end else begin
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts it out on sdo,
// with sgate marking the last (stable) cycle of every bit period.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sgate,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             timer_start;
    logic             timer_en;
    logic             last_bit;

    function automatic logic head_of(input logic [WIDTH-1:0] v);
        return (MSB_FIRST == ORDER_MSB_FIRST) ? v[WIDTH-1] : v[0];
    endfunction

    always_comb begin
        if (MSB_FIRST == ORDER_MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign last_bit    = tick && (bit_cnt == '0);
    assign timer_start = (state == IDLE) && din_valid && din_ready;
    // Timer stops on the final bit so no stray tick leaks into the DONE cycle.
    assign timer_en    = (state == SHIFT) && !last_bit;

    bit_timer #(
        .DIV(DIV)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .start(timer_start),
        .en   (timer_en),
        .tick (tick)
    );

    assign sgate = tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            din_ready <= 1'b1;
            sdo       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (din_valid && din_ready) begin
                        state     <= SHIFT;
                        shreg     <= din;
                        bit_cnt   <= BW'(WIDTH - 1);
                        din_ready <= 1'b0;
                        busy      <= 1'b1;
                        sdo       <= head_of(din);
                    end else begin
                        din_ready <= 1'b1;
                        busy      <= 1'b0;
                        sdo       <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        state <= DONE;
                        done  <= 1'b1;
                        sdo   <= 1'b0;
                    end else if (tick) begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt - 1'b1;
                        sdo     <= head_of(shifted);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    din_ready <= 1'b1;
                    sdo       <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    bit_cnt   <= '0;
                    din_ready <= 1'b1;
                    sdo       <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
